reaction_delay_timer: RTL and testbench

- Downstream stage of the starting-lights sequencer in the reaction-timer design.
- On the sequencer's start_delay request, captures the frozen LFSR value as a random delay in ms and counts it down on the 1 ms tick.
- Raises timeout to the sequencer at "lights out", then measures the player's reaction time in ms until the react button.
- Presents the result to the display/BCD stage with a one-cycle valid strobe.

---
 rtl/reaction_delay_timer.sv | 162 ++++++++++++++++
 tb/tb_reaction_delay_timer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_delay_timer.sv
// ---------------------------------------------------------------------------
// reaction_delay_timer: random start delay countdown, then reaction time in ms
// Optional macro FALSE_START_DETECT_EN adds false_start (react during COUNT)
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module reaction_delay_timer #(
  parameter int LFSR_W    = 14,
  parameter int MIN_DELAY = 250,
  parameter int RT_W      = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start_delay,
  input  logic [LFSR_W-1:0] lfsr_value,
  input  logic              react,
  output logic              timeout,
  output logic              busy,
  output logic [RT_W-1:0]   reaction_ms,
  output logic              valid
`ifdef FALSE_START_DETECT_EN
  ,
  output logic              false_start
`endif
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COUNT      = 3'd1,
    LIGHTS_OUT = 3'd2,
    MEASURE    = 3'd3,
    DONE       = 3'd4
  } state_t;

  localparam logic [LFSR_W-1:0] MIN_D  = LFSR_W'(MIN_DELAY);
  localparam logic [RT_W-1:0]   RT_MAX = '1;

  state_t              state, state_n;
  logic                start_q;
  logic [LFSR_W-1:0]   delay_cnt, delay_n;
  logic [RT_W-1:0]     rt_cnt, rt_n, reaction_n;
  logic                timeout_n, valid_n;
  logic                lo_tick, lo_tick_n;
  logic                start_rise;
  logic                fs_abort;
  logic [LFSR_W-1:0]   delay_load;
  logic [RT_W-1:0]     rt_inc;

  assign start_rise = start_delay & ~start_q;
  assign delay_load = (lfsr_value < MIN_D) ? MIN_D : lfsr_value;
  assign rt_inc     = (rt_cnt == RT_MAX) ? rt_cnt : rt_cnt + 1'b1;
  assign busy       = (state != IDLE) && (state != DONE);

`ifdef FALSE_START_DETECT_EN
  logic fs_n;
  assign fs_abort = react;
`else
  assign fs_abort = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    delay_n    = delay_cnt;
    rt_n       = rt_cnt;
    reaction_n = reaction_ms;
    timeout_n  = timeout;
    valid_n    = 1'b0;
    lo_tick_n  = lo_tick;
`ifdef FALSE_START_DETECT_EN
    fs_n       = false_start;
`endif
    case (state)
      IDLE: begin
        if (start_rise) begin
          delay_n = delay_load;
          state_n = COUNT;
`ifdef FALSE_START_DETECT_EN
          fs_n    = 1'b0;
`endif
        end
      end
      COUNT: begin
        if (fs_abort) begin
          reaction_n = RT_MAX;
          valid_n    = 1'b1;
          delay_n    = '0;
          state_n    = DONE;
`ifdef FALSE_START_DETECT_EN
          fs_n       = 1'b1;
`endif
        end else if (tick) begin
          if (delay_cnt <= LFSR_W'(1)) begin
            delay_n   = '0;
            timeout_n = 1'b1;
            rt_n      = '0;
            lo_tick_n = 1'b0;
            state_n   = LIGHTS_OUT;
          end else begin
            delay_n = delay_cnt - 1'b1;
          end
        end
      end
      LIGHTS_OUT, MEASURE: begin
        if (react) begin
          reaction_n = rt_cnt;
          valid_n    = 1'b1;
          timeout_n  = 1'b0;
          state_n    = DONE;
        end else if (tick) begin
          rt_n = rt_inc;
          // timeout survives the first tick after entry and drops on the second
          if (state == LIGHTS_OUT) begin
            if (lo_tick) begin
              timeout_n = 1'b0;
              state_n   = MEASURE;
            end else begin
              lo_tick_n = 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (!react && !start_delay) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      delay_cnt   <= '0;
      rt_cnt      <= '0;
      reaction_ms <= '0;
      timeout     <= 1'b0;
      valid       <= 1'b0;
      lo_tick     <= 1'b0;
`ifdef FALSE_START_DETECT_EN
      false_start <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      start_q     <= start_delay;
      delay_cnt   <= delay_n;
      rt_cnt      <= rt_n;
      reaction_ms <= reaction_n;
      timeout     <= timeout_n;
      valid       <= valid_n;
      lo_tick     <= lo_tick_n;
`ifdef FALSE_START_DETECT_EN
      false_start <= fs_n;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reaction_delay_timer.sv
// ---------------------------------------------------------------------------
// tb_reaction_delay_timer: directed vectors with a valid-driven scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_reaction_delay_timer;

  logic        clk = 1'b0;
  logic        rst, tick, start_delay, react;
  logic [13:0] lfsr_value;
  logic        timeout, busy, valid;
  logic [13:0] reaction_ms;
`ifdef FALSE_START_DETECT_EN
  logic        false_start;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];
  logic valid_d = 1'b0;

  reaction_delay_timer #(.LFSR_W(14), .MIN_DELAY(250), .RT_W(14)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start_delay(start_delay),
    .lfsr_value (lfsr_value),
    .react      (react),
    .timeout    (timeout),
    .busy       (busy),
    .reaction_ms(reaction_ms),
    .valid      (valid)
`ifdef FALSE_START_DETECT_EN
    ,
    .false_start(false_start)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse pops one expected reaction time
  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got reaction_ms=%0d expected no strobe", reaction_ms);
      end else begin
        check("reaction_ms", 32'(reaction_ms), 32'(exp_q.pop_front()));
      end
      if (valid_d) begin
        vectors++;
        miscompares++;
        $display("FAIL valid_width: got valid high 2+ cycles expected 1");
      end
    end
    valid_d = valid;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(2);
    end
  endtask

  task automatic ticks_until_timeout(input int limit, output int n);
    n = 0;
    while (!timeout && n < limit) begin
      ticks(1);
      n++;
    end
  endtask

  task automatic start_run(input logic [13:0] lfsr, input logic tick_on_edge);
    lfsr_value  = lfsr;
    start_delay = 1'b1;
    tick        = tick_on_edge;
    cyc(1);
    tick = 1'b0;
    check("busy_after_edge", 32'(busy), 32'd1);
    cyc(2);
  endtask

  task automatic press(input int exp);
    react = 1'b1;
    exp_q.push_back(exp);
    cyc(1);
    react = 1'b0;
    cyc(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; tick = 1'b0; start_delay = 1'b0; react = 1'b0; lfsr_value = '0;
    cyc(3);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_reaction_ms", 32'(reaction_ms), 32'd0);
    rst = 1'b0;
    cyc(1);

    // Reset during countdown aborts without a result
    start_run(14'd500, 1'b0);
    ticks(100);
    check("mid_count_busy", 32'(busy), 32'd1);
    rst = 1'b1; start_delay = 1'b0;
    cyc(1);
    rst = 1'b0;
    check("rst_abort_busy", 32'(busy), 32'd0);
    check("rst_abort_timeout", 32'(timeout), 32'd0);
    ticks(450);
    check("rst_abort_stays_idle", 32'({busy, timeout}), 32'd0);

    // 300 ms delay with start held; timeout spans a full tick; react after 187 ticks
    start_run(14'd300, 1'b0);
    ticks_until_timeout(400, n);
    check("delay_300_ticks", 32'(n), 32'd300);
    ticks(1);
    check("timeout_after_tick1", 32'(timeout), 32'd1);
    ticks(1);
    check("timeout_after_tick2", 32'(timeout), 32'd0);
    start_delay = 1'b0;
    ticks(185);
    react = 1'b1;
    exp_q.push_back(187);
    cyc(3);
    check("done_busy_low", 32'(busy), 32'd0);
    start_delay = 1'b1;
    cyc(3);
    check("no_retrigger_in_done", 32'(busy), 32'd0);
    start_delay = 1'b0; react = 1'b0;
    cyc(3);

    // Below-minimum delay, immediate react gives 0
    start_run(14'd5, 1'b0);
    ticks_until_timeout(400, n);
    check("delay_5_clamped", 32'(n), 32'd250);
    start_delay = 1'b0;
    press(0);

    // Zero delay with a tick on the edge cycle; react coincident with tick 10
    start_run(14'd0, 1'b1);
    ticks_until_timeout(400, n);
    check("delay_0_clamped", 32'(n), 32'd250);
    start_delay = 1'b0;
    ticks(9);
    tick = 1'b1; react = 1'b1;
    exp_q.push_back(9);
    cyc(1);
    tick = 1'b0; react = 1'b0;
    cyc(2);

    // Saturation of the reaction counter
    start_run(14'd250, 1'b0);
    ticks_until_timeout(400, n);
    check("sat_delay", 32'(n), 32'd250);
    start_delay = 1'b0;
    ticks(16384 + 10);
    press(16383);

    // React during countdown at tick 50 of 400
    start_run(14'd400, 1'b0);
    start_delay = 1'b0;
    ticks(49);
    tick = 1'b1; react = 1'b1;
`ifdef FALSE_START_DETECT_EN
    exp_q.push_back(16383);
`endif
    cyc(1);
    tick = 1'b0; react = 1'b0;
    cyc(2);
`ifdef FALSE_START_DETECT_EN
    check("false_start_set", 32'(false_start), 32'd1);
    check("false_start_busy", 32'(busy), 32'd0);
    ticks(400);
    check("false_start_no_timeout", 32'(timeout), 32'd0);
    start_run(14'd300, 1'b0);
    check("false_start_cleared", 32'(false_start), 32'd0);
    rst = 1'b1; start_delay = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(1);
`else
    ticks_until_timeout(400, n);
    check("react_in_count_ignored", 32'(n + 50), 32'd400);
    press(0);
`endif

    cyc(5);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
